// File: rtl/sensor_monitor_n.sv
// N-channel sensor monitor: per-channel synchroniser and debouncer, status LEDs, V_sense,
// and an alarm FSM with recovery hold, sticky fault flags and a saturating fault-event counter.
module sensor_monitor_n #(
    parameter int N_SENSORS       = 3,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int RECOVER_CYCLES  = 8,
    parameter int CNT_W           = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_SENSORS-1:0] chaves_sensores,
    input  logic [N_SENSORS-1:0] sensor_en,
    input  logic                 clear_faults,
    output logic [N_SENSORS-1:0] leds,
    output logic                 V_sense,
    output logic                 alarm,
    output logic [1:0]           state,
    output logic [N_SENSORS-1:0] fault_latched,
    output logic [CNT_W-1:0]     fault_events
);

    localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int RC_W = (RECOVER_CYCLES > 1) ? $clog2(RECOVER_CYCLES) : 1;
    localparam logic [DB_W-1:0]  DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [RC_W-1:0]  RC_LAST = RC_W'(RECOVER_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        ST_NORMAL  = 2'b00,
        ST_ALARM   = 2'b01,
        ST_RECOVER = 2'b10
    } state_t;

    logic [N_SENSORS-1:0] sync_1;
    logic [N_SENSORS-1:0] sync_2;
    logic [N_SENSORS-1:0] stable;
    logic [DB_W-1:0]      db_cnt [N_SENSORS];
    logic [N_SENSORS-1:0] fault_now;

    state_t          state_q;
    state_t          state_d;
    logic [RC_W-1:0] rcnt_q;
    logic [RC_W-1:0] rcnt_d;
    logic            alarm_event;

    // Two-flop synchroniser; reset to the healthy level so nothing faults out of reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_1 <= '1;
            sync_2 <= '1;
        end else begin
            sync_1 <= chaves_sensores;
            sync_2 <= sync_1;
        end
    end

    // A new level is accepted only after it has differed from the stable level on
    // DEBOUNCE_CYCLES consecutive edges; any return to the old level restarts the run.
    always_ff @(posedge clk) begin
        if (rst) begin
            stable <= '1;
            for (int i = 0; i < N_SENSORS; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_SENSORS; i++) begin
                if (sync_2[i] == stable[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    stable[i] <= sync_2[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign leds      = stable;
    assign fault_now = sensor_en & ~stable;
    assign V_sense   = |fault_now;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_NORMAL;
            rcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            rcnt_q  <= rcnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        rcnt_d      = rcnt_q;
        alarm_event = 1'b0;
        unique case (state_q)
            ST_NORMAL: begin
                if (V_sense) begin
                    state_d     = ST_ALARM;
                    alarm_event = 1'b1;
                end
            end
            ST_ALARM: begin
                if (!V_sense) begin
                    state_d = ST_RECOVER;
                    rcnt_d  = '0;
                end
            end
            ST_RECOVER: begin
                if (V_sense) begin
                    state_d     = ST_ALARM;
                    alarm_event = 1'b1;
                end else if (rcnt_q == RC_LAST) begin
                    state_d = ST_NORMAL;
                end else begin
                    rcnt_d = rcnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_NORMAL;
            end
        endcase
    end

    assign state = state_q;
    assign alarm = (state_q != ST_NORMAL);

    // A fault present in the clear cycle wins over the clear, and an event in the
    // clear cycle is the first count of the new epoch.
    always_ff @(posedge clk) begin
        if (rst) begin
            fault_latched <= '0;
            fault_events  <= '0;
        end else begin
            fault_latched <= fault_now | (fault_latched & ~{N_SENSORS{clear_faults}});
            if (clear_faults) begin
                fault_events <= alarm_event ? CNT_W'(1) : '0;
            end else if (alarm_event && (fault_events != CNT_MAX)) begin
                fault_events <= fault_events + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sensor_monitor_n.sv
// Directed bench for sensor_monitor_n: a behavioural model is checked every cycle,
// and hand-computed literals pin the latency, recovery hold, clear and saturation cases.
module tb_sensor_monitor_n;

    localparam int N    = 3;
    localparam int D    = 4;
    localparam int R    = 8;
    localparam int W    = 8;
    localparam int MAXV = (1 << W) - 1;

    logic         clk = 1'b0;
    logic         rst;
    logic         clear_faults;
    logic [N-1:0] raw;
    logic [N-1:0] en;
    logic [N-1:0] leds;
    logic [N-1:0] fault_latched;
    logic         v_sense;
    logic         alarm;
    logic [1:0]   state;
    logic [W-1:0] fault_events;

    int errors = 0;
    int checks = 0;

    // Model: raw-sample delay line, recent synchronised history, and plain FSM bookkeeping.
    logic [N-1:0] raw_q[$];
    logic [N-1:0] shist[$];
    logic [N-1:0] m_stable;
    logic [N-1:0] m_latched;
    int           m_state;
    int           m_clean;
    int           m_events;
    bit           vs_seen;

    sensor_monitor_n #(
        .N_SENSORS      (N),
        .DEBOUNCE_CYCLES(D),
        .RECOVER_CYCLES (R),
        .CNT_W          (W)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .chaves_sensores(raw),
        .sensor_en      (en),
        .clear_faults   (clear_faults),
        .leds           (leds),
        .V_sense        (v_sense),
        .alarm          (alarm),
        .state          (state),
        .fault_latched  (fault_latched),
        .fault_events   (fault_events)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Applies one rising edge to the model using the inputs present before that edge.
    task automatic model_edge();
        logic [N-1:0] sync;
        logic [N-1:0] col;
        logic         vs;
        logic         ev;
        bit           all_diff;
        if (rst) begin
            raw_q.delete();
            raw_q.push_back({N{1'b1}});
            raw_q.push_back({N{1'b1}});
            shist.delete();
            m_stable  = '1;
            m_latched = '0;
            m_state   = 0;
            m_clean   = 0;
            m_events  = 0;
            return;
        end
        vs = |(en & ~m_stable);
        ev = 1'b0;
        case (m_state)
            0: if (vs) begin m_state = 1; ev = 1'b1; end
            1: if (!vs) begin m_state = 2; m_clean = 0; end
            default: begin
                if (vs) begin
                    m_state = 1;
                    ev      = 1'b1;
                end else begin
                    m_clean++;
                    if (m_clean == R) m_state = 0;
                end
            end
        endcase
        m_latched = (en & ~m_stable) | (m_latched & ~{N{clear_faults}});
        if (clear_faults) m_events = ev ? 1 : 0;
        else if (ev && m_events < MAXV) m_events++;
        sync = raw_q.pop_front();
        raw_q.push_back(raw);
        shist.push_back(sync);
        if (shist.size() > D) void'(shist.pop_front());
        if (shist.size() == D) begin
            for (int i = 0; i < N; i++) begin
                all_diff = 1'b1;
                for (int k = 0; k < D; k++) begin
                    col = shist[k];
                    if (col[i] == m_stable[i]) all_diff = 1'b0;
                end
                if (all_diff) m_stable[i] = sync[i];
            end
        end
    endtask

    task automatic check_all();
        chk("leds", 32'(leds), 32'(m_stable));
        chk("v_sense", 32'(v_sense), 32'(|(en & ~m_stable)));
        chk("state", 32'(state), 32'(m_state));
        chk("alarm", 32'(alarm), 32'(m_state != 0));
        chk("fault_latched", 32'(fault_latched), 32'(m_latched));
        chk("fault_events", 32'(fault_events), 32'(m_events));
        if (v_sense) vs_seen = 1'b1;
    endtask

    task automatic tick(input int n = 1);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            model_edge();
            @(negedge clk);
            check_all();
        end
    endtask

    initial begin
        rst          = 1'b1;
        raw          = '1;
        en           = '1;
        clear_faults = 1'b0;
        vs_seen      = 1'b0;
        tick(2);
        rst = 1'b0;

        // Idle after reset
        tick(20);
        chk("t1_leds", 32'(leds), 7);
        chk("t1_vsense", 32'(v_sense), 0);
        chk("t1_state", 32'(state), 0);
        chk("t1_events", 32'(fault_events), 0);

        // Short glitch on channel 0 is rejected
        vs_seen = 1'b0;
        raw[0]  = 1'b0;
        tick(3);
        raw[0] = 1'b1;
        tick(10);
        chk("t3_leds", 32'(leds), 7);
        chk("t3_vsense_seen", 32'(vs_seen), 0);
        chk("t3_events", 32'(fault_events), 0);

        // Channel 1 drops: accepted at E+5, alarm one edge later
        raw[1] = 1'b0;
        tick(5);
        chk("t2_led1_at_e4", 32'(leds[1]), 1);
        tick(1);
        chk("t2_led1_at_e5", 32'(leds[1]), 0);
        chk("t2_vsense", 32'(v_sense), 1);
        chk("t2_state_pre", 32'(state), 0);
        tick(1);
        chk("t2_state", 32'(state), 1);
        chk("t2_events", 32'(fault_events), 1);
        chk("t2_latched", 32'(fault_latched), 2);

        // Restore, then the fault returns during the fourth RECOVER cycle
        raw[1] = 1'b1;
        tick(4);
        raw[1] = 1'b0;
        tick(2);
        chk("t4a_vsense_clear", 32'(v_sense), 0);
        chk("t4a_still_alarm", 32'(state), 1);
        tick(1);
        chk("t4a_recover", 32'(state), 2);
        tick(3);
        chk("t4a_recover_c4", 32'(state), 2);
        chk("t4a_vsense_back", 32'(v_sense), 1);
        tick(1);
        chk("t4a_realarm", 32'(state), 1);
        chk("t4a_events", 32'(fault_events), 2);

        // Restore and hold: 8 RECOVER cycles then NORMAL
        raw[1] = 1'b1;
        tick(6);
        chk("t4b_vsense_clear", 32'(v_sense), 0);
        tick(1);
        chk("t4b_recover", 32'(state), 2);
        tick(7);
        chk("t4b_recover_last", 32'(state), 2);
        chk("t4b_alarm_out", 32'(alarm), 1);
        tick(1);
        chk("t4b_normal", 32'(state), 0);
        chk("t4b_latched", 32'(fault_latched), 2);
        chk("t4b_events", 32'(fault_events), 2);

        clear_faults = 1'b1;
        tick(1);
        clear_faults = 1'b0;
        chk("clr_latched", 32'(fault_latched), 0);
        chk("clr_events", 32'(fault_events), 0);

        // Disabled channel never faults; enabling it shows on V_sense immediately
        en     = 3'b101;
        raw[1] = 1'b0;
        tick(8);
        chk("t5_leds", 32'(leds), 5);
        chk("t5_vsense_masked", 32'(v_sense), 0);
        chk("t5_state_masked", 32'(state), 0);
        en = 3'b111;
        #1;
        chk("t5_vsense_same_cycle", 32'(v_sense), 1);
        tick(1);
        chk("t5_state", 32'(state), 1);
        chk("t5_events", 32'(fault_events), 1);

        // Back to NORMAL via masking, then clear coincides with NORMAL->ALARM
        en = 3'b101;
        tick(1);
        tick(R);
        chk("t6_normal", 32'(state), 0);
        en           = 3'b111;
        clear_faults = 1'b1;
        tick(1);
        clear_faults = 1'b0;
        chk("t6_clr_state", 32'(state), 1);
        chk("t6_clr_events", 32'(fault_events), 1);
        chk("t6_clr_latched", 32'(fault_latched), 2);

        // 300 RECOVER->ALARM events saturate the counter
        for (int j = 0; j < 300; j++) begin
            en = 3'b101;
            tick(1);
            en = 3'b111;
            tick(1);
        end
        chk("t6_saturate", 32'(fault_events), 255);

        // Reset in the middle of RECOVER
        en = 3'b101;
        tick(3);
        chk("t6_mid_recover", 32'(state), 2);
        rst = 1'b1;
        tick(1);
        chk("t6_rst_state", 32'(state), 0);
        chk("t6_rst_leds", 32'(leds), 7);
        chk("t6_rst_vsense", 32'(v_sense), 0);
        chk("t6_rst_alarm", 32'(alarm), 0);
        chk("t6_rst_events", 32'(fault_events), 0);
        chk("t6_rst_latched", 32'(fault_latched), 0);
        rst = 1'b0;
        tick(10);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        errors++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
